// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
// Display register and font stage for a 4-digit multiplexed 7-segment driver.
// The CPU writes nibbles into a shadow bank. An update strobe copies the whole
// shadow bank into the display bank in one edge, so the display never shows a
// half-written value. Each digit's pattern is built from the display bank:
// hex font, leading-zero blanking, decimal point and blink. The pattern is
// registered before it leaves the block.
//
// Ports
//   clk        system clock (12 MHz nominal)
//   rst_n      asynchronous active-low reset
//   wrEn       shadow write strobe
//   wrAddr     shadow select: 0..3 digit nibble, 4 dpMask, 5 blinkMask,
//              6 ctrl (bit0 = lzEn), 7 no effect
//   wrData     write data
//   update     commit shadow bank to display bank (includes a same-cycle write)
//   segA..segD active-low {dp,g,f,e,d,c,b,a}; segA is the rightmost digit
//   blinkPhase 1 = digits selected for blinking are dark
// -----------------------------------------------------------------------------
module seg_display_ctrl #(
  parameter logic [23:0] BLINK_HALF = 24'd6000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrEn,
  input  logic [2:0] wrAddr,
  input  logic [3:0] wrData,
  input  logic       update,
  output logic [7:0] segA,
  output logic [7:0] segB,
  output logic [7:0] segC,
  output logic [7:0] segD,
  output logic       blinkPhase
);

  // Hex font, active-low, dp off.
  function automatic logic [7:0] font_hex(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      4'hF: pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  // Full digit pattern. The dp survives leading-zero blanking, but blink
  // darkens everything including the dp.
  function automatic logic [7:0] digit_pattern(input logic [3:0] nib,
                                               input logic       dp_on,
                                               input logic       lz_blank,
                                               input logic       blink_dark);
    logic [7:0] pat;
    if (lz_blank) begin
      pat = 8'hFF;
    end else begin
      pat = font_hex(nib);
    end
    if (dp_on) begin
      pat[7] = 1'b0;
    end else begin
      pat[7] = pat[7];
    end
    if (blink_dark) begin
      pat = 8'hFF;
    end else begin
      pat = pat;
    end
    return pat;
  endfunction

  // Shadow bank (CPU-facing) and display bank (what is shown).
  logic [15:0] sh_nib_r, sh_nib_s, dsp_nib_r;
  logic [3:0]  sh_dp_r, sh_dp_s, dsp_dp_r;
  logic [3:0]  sh_blink_r, sh_blink_s, dsp_blink_r;
  logic        sh_lz_r, sh_lz_s, dsp_lz_r;

  logic [23:0] blink_cnt_r;
  logic        blink_phase_r;
  logic        blink_wrap_s;

  logic [7:0]  seg_a_r, seg_b_r, seg_c_r, seg_d_r;
  logic [7:0]  seg_a_s, seg_b_s, seg_c_s, seg_d_s;
  logic        blank3_s, blank2_s, blank1_s;

  // Shadow bank with this cycle's write applied; also the value a commit takes,
  // which is how a write in the same cycle as update reaches the display.
  always_comb begin
    sh_nib_s   = sh_nib_r;
    sh_dp_s    = sh_dp_r;
    sh_blink_s = sh_blink_r;
    sh_lz_s    = sh_lz_r;
    if (wrEn) begin
      case (wrAddr)
        3'd0:    sh_nib_s[3:0]   = wrData;
        3'd1:    sh_nib_s[7:4]   = wrData;
        3'd2:    sh_nib_s[11:8]  = wrData;
        3'd3:    sh_nib_s[15:12] = wrData;
        3'd4:    sh_dp_s         = wrData;
        3'd5:    sh_blink_s      = wrData;
        3'd6:    sh_lz_s         = wrData[0];
        default: sh_lz_s         = sh_lz_r;
      endcase
    end else begin
      sh_lz_s = sh_lz_r;
    end
  end

  // Shadow bank register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_nib_r   <= 16'h0000;
      sh_dp_r    <= 4'h0;
      sh_blink_r <= 4'h0;
      sh_lz_r    <= 1'b0;
    end else begin
      sh_nib_r   <= sh_nib_s;
      sh_dp_r    <= sh_dp_s;
      sh_blink_r <= sh_blink_s;
      sh_lz_r    <= sh_lz_s;
    end
  end

  // Display bank: atomic copy of the (forwarded) shadow bank on update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_nib_r   <= 16'h0000;
      dsp_dp_r    <= 4'h0;
      dsp_blink_r <= 4'h0;
      dsp_lz_r    <= 1'b0;
    end else if (update) begin
      dsp_nib_r   <= sh_nib_s;
      dsp_dp_r    <= sh_dp_s;
      dsp_blink_r <= sh_blink_s;
      dsp_lz_r    <= sh_lz_s;
    end else begin
      dsp_nib_r   <= dsp_nib_r;
      dsp_dp_r    <= dsp_dp_r;
      dsp_blink_r <= dsp_blink_r;
      dsp_lz_r    <= dsp_lz_r;
    end
  end

  assign blink_wrap_s = (blink_cnt_r == (BLINK_HALF - 24'd1));

  // Free-running blink timer; phase flips on every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r   <= 24'd0;
      blink_phase_r <= 1'b0;
    end else if (blink_wrap_s) begin
      blink_cnt_r   <= 24'd0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + 24'd1;
      blink_phase_r <= blink_phase_r;
    end
  end

  // Leading-zero chain: a digit blanks only if it and every digit to its left
  // are zero; digit 0 always shows.
  always_comb begin
    blank3_s = dsp_lz_r && (dsp_nib_r[15:12] == 4'h0);
    blank2_s = blank3_s && (dsp_nib_r[11:8] == 4'h0);
    blank1_s = blank2_s && (dsp_nib_r[7:4] == 4'h0);
    seg_a_s  = digit_pattern(dsp_nib_r[3:0], dsp_dp_r[0], 1'b0,
                             dsp_blink_r[0] && blink_phase_r);
    seg_b_s  = digit_pattern(dsp_nib_r[7:4], dsp_dp_r[1], blank1_s,
                             dsp_blink_r[1] && blink_phase_r);
    seg_c_s  = digit_pattern(dsp_nib_r[11:8], dsp_dp_r[2], blank2_s,
                             dsp_blink_r[2] && blink_phase_r);
    seg_d_s  = digit_pattern(dsp_nib_r[15:12], dsp_dp_r[3], blank3_s,
                             dsp_blink_r[3] && blink_phase_r);
  end

  // Output pattern registers; reset shows "0000".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_a_r <= 8'hC0;
      seg_b_r <= 8'hC0;
      seg_c_r <= 8'hC0;
      seg_d_r <= 8'hC0;
    end else begin
      seg_a_r <= seg_a_s;
      seg_b_r <= seg_b_s;
      seg_c_r <= seg_c_s;
      seg_d_r <= seg_d_s;
    end
  end

  assign segA       = seg_a_r;
  assign segB       = seg_b_r;
  assign segC       = seg_c_r;
  assign segD       = seg_d_r;
  assign blinkPhase = blink_phase_r;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_display_ctrl
// Directed table of write/update cycles with hand-computed segment patterns,
// followed by hand-written blink and reset-during-operation sequences.
// The DUT runs with a blink half-period of 4 clocks.
// -----------------------------------------------------------------------------
module tb_seg_display_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wrEn;
  logic [2:0] wrAddr;
  logic [3:0] wrData;
  logic       update;
  logic [7:0] segA, segB, segC, segD;
  logic       blinkPhase;

  int vectors;
  int miscompares;

  seg_display_ctrl #(.BLINK_HALF(24'd4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .update     (update),
    .segA       (segA),
    .segB       (segB),
    .segC       (segC),
    .segD       (segD),
    .blinkPhase (blinkPhase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [3:0] data;
    logic       upd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [26];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_segs(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    check8({name, ".segA"}, segA, a);
    check8({name, ".segB"}, segB, b);
    check8({name, ".segC"}, segC, c);
    check8({name, ".segD"}, segD, d);
  endtask

  task automatic drive(input logic we, input logic [2:0] addr, input logic [3:0] data,
                       input logic upd);
    wrEn   = we;
    wrAddr = addr;
    wrData = data;
    update = upd;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    // Each row is one clock: inputs for that edge, outputs seen after it.
    tbl[0]  = '{1'b1, 3'd0, 4'h1, 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    tbl[1]  = '{1'b1, 3'd1, 4'h2, 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    tbl[2]  = '{1'b1, 3'd2, 4'h3, 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    tbl[3]  = '{1'b1, 3'd3, 4'h4, 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    tbl[4]  = '{1'b0, 3'd0, 4'h0, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    tbl[5]  = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hF9, 8'hA4, 8'hB0, 8'h99};
    tbl[6]  = '{1'b1, 3'd0, 4'hF, 1'b1, 8'hF9, 8'hA4, 8'hB0, 8'h99};
    tbl[7]  = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[8]  = '{1'b0, 3'd0, 4'h0, 1'b1, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[9]  = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[10] = '{1'b1, 3'd0, 4'h5, 1'b0, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[11] = '{1'b1, 3'd1, 4'h0, 1'b0, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[12] = '{1'b1, 3'd2, 4'h0, 1'b0, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[13] = '{1'b1, 3'd3, 4'h0, 1'b0, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[14] = '{1'b1, 3'd6, 4'h1, 1'b1, 8'h8E, 8'hA4, 8'hB0, 8'h99};
    tbl[15] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h92, 8'hFF, 8'hFF, 8'hFF};
    tbl[16] = '{1'b1, 3'd0, 4'h0, 1'b1, 8'h92, 8'hFF, 8'hFF, 8'hFF};
    tbl[17] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
    tbl[18] = '{1'b1, 3'd4, 4'h4, 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
    tbl[19] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hC0, 8'hFF, 8'h7F, 8'hFF};
    tbl[20] = '{1'b1, 3'd7, 4'hF, 1'b1, 8'hC0, 8'hFF, 8'h7F, 8'hFF};
    tbl[21] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hC0, 8'hFF, 8'h7F, 8'hFF};
    tbl[22] = '{1'b1, 3'd6, 4'hF, 1'b1, 8'hC0, 8'hFF, 8'h7F, 8'hFF};
    tbl[23] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hC0, 8'hFF, 8'h7F, 8'hFF};
    tbl[24] = '{1'b1, 3'd6, 4'hE, 1'b1, 8'hC0, 8'hFF, 8'h7F, 8'hFF};
    tbl[25] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hC0, 8'hC0, 8'h40, 8'hC0};

    // Reset asserted asynchronously before the first edge.
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_segs("reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check8("reset.phase", {7'd0, blinkPhase}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_segs("idle10", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Table: write/commit, forwarding, leading zero, dp, addr 7, ctrl bits.
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].upd);
      @(negedge clk);
      check_segs($sformatf("tbl[%0d]", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0);

    // Mid-cycle reset clears a visibly non-default display at once.
    #2 rst_n = 1'b0;
    #1;
    check_segs("midreset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;

    // Blink: nibble0=8, blinkMask=0001, committed at edge 2 after release.
    // Phase after edge e is (e/4)%2; segA after edge e reflects phase after e-1.
    for (int e = 1; e <= 20; e++) begin
      if (e == 1) begin
        drive(1'b1, 3'd0, 4'h8, 1'b0);
      end else if (e == 2) begin
        drive(1'b1, 3'd5, 4'h1, 1'b1);
      end else begin
        drive(1'b0, 3'd0, 4'h0, 1'b0);
      end
      @(negedge clk);
      check8($sformatf("blink[%0d].phase", e), {7'd0, blinkPhase},
             (((e / 4) % 2) == 1) ? 8'h01 : 8'h00);
      check8($sformatf("blink[%0d].segA", e), segA,
             (e < 3) ? 8'hC0 : ((((e - 1) / 4) % 2) == 1) ? 8'hFF : 8'h80);
      check8($sformatf("blink[%0d].segB", e), segB, 8'hC0);
      check8($sformatf("blink[%0d].segD", e), segD, 8'hC0);
    end

    // Pending shadow write, then reset while phase=1: write must be lost,
    // phase back to 0 and counter restarted.
    drive(1'b1, 3'd1, 4'h9, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check8("rst_blink.phase", {7'd0, blinkPhase}, 8'h00);
    check8("rst_blink.segA", segA, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 4'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'd0, 4'h0, 1'b0);
    @(negedge clk);
    check_segs("post_rst_commit", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check8("post_rst.phase_e2", {7'd0, blinkPhase}, 8'h00);
    @(negedge clk);
    check8("post_rst.phase_e3", {7'd0, blinkPhase}, 8'h00);
    @(negedge clk);
    check8("post_rst.phase_e4", {7'd0, blinkPhase}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
